// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller (master) and the
// four-bank main memory (slave).
interface four_bank_mem_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic              wr;
  logic              rd;
  logic [15:0]       data_out;
  logic              data_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, data_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, data_valid, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem.sv
// Four-way word-interleaved main memory: per-bank occupancy counters and a
// fixed two-stage read pipeline in front of four single-port arrays.
module four_bank_mem #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned BANK_CYC = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  four_bank_mem_if.slave bus
);

  localparam int unsigned RowW    = ADDR_W - 3;
  localparam int unsigned Depth   = 2 ** RowW;
  localparam logic [3:0]  CntLoad = 4'(BANK_CYC - 1);

  logic [1:0]      bank;
  logic [RowW-1:0] row;
  logic            legal;
  logic            accept;

  logic [3:0]  cnt_q [4];
  logic [3:0]  cnt_d [4];
  logic [3:0]  busy_q;
  logic [3:0]  busy_d;
  logic [15:0] rdata [4];

  logic        s1_valid_q;
  logic [1:0]  s1_bank_q;
  logic        dv_q;
  logic [15:0] dout_q;

  assign bank = bus.addr[2:1];
  assign row  = bus.addr[ADDR_W-1:3];

  // A request is legal only as a single rd or wr to an even byte address.
  assign legal  = (bus.rd ^ bus.wr) & ~bus.addr[0];
  assign accept = ~rst_i & legal & ~busy_q[bank];

  assign bus.err        = ~rst_i & (bus.rd | bus.wr) & ~legal;
  assign bus.stall      = ~rst_i & legal & busy_q[bank];
  assign bus.busy       = busy_q;
  assign bus.data_valid = dv_q;
  assign bus.data_out   = dout_q;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      cnt_d[b] = (cnt_q[b] != 4'd0) ? cnt_q[b] - 4'd1 : 4'd0;
      if (accept && (bank == 2'(b))) begin
        cnt_d[b] = CntLoad;
      end
      busy_d[b] = (cnt_d[b] != 4'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= 4'd0;
      end
      busy_q <= 4'b0000;
    end else begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [15:0] mem_q [Depth];
    logic [15:0] rdata_q;

    // Array contents and the read register are deliberately never reset.
    always_ff @(posedge clk_i) begin
      if (accept && (bank == 2'(g))) begin
        if (bus.wr) begin
          mem_q[row] <= bus.data_in;
        end else begin
          rdata_q <= mem_q[row];
        end
      end
    end

    assign rdata[g] = rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_bank_q  <= 2'd0;
      dv_q       <= 1'b0;
      dout_q     <= 16'h0000;
    end else begin
      s1_valid_q <= accept & bus.rd;
      s1_bank_q  <= bank;
      dv_q       <= s1_valid_q;
      dout_q     <= s1_valid_q ? rdata[s1_bank_q] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_four_bank_mem.sv
// Randomised and directed check of four_bank_mem (BANK_CYC=4 and 2 side by side)
// against a cycle-stamped behavioural model.
module tb_four_bank_mem;

  localparam int unsigned AW   = 16;
  localparam int          NCYC = 8192;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  four_bank_mem_if #(.ADDR_W(AW)) bus0 ();
  four_bank_mem_if #(.ADDR_W(AW)) bus1 ();

  four_bank_mem #(.ADDR_W(AW), .BANK_CYC(4)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  four_bank_mem #(.ADDR_W(AW), .BANK_CYC(2)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bc [2]   = '{4, 2};

  // Model: first cycle each bank is free again, reads due per cycle, word contents.
  int          free_c [2][4];
  bit          pend_v [2][NCYC];
  logic [15:0] pend_d [2][NCYC];
  logic [15:0] mem_m  [2][32768];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_free();
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++)
        if (free_c[i][b] > cyc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic rd_v, input logic wr_v,
                      input logic [15:0] a, input logic [15:0] d, output bit acc0);
    rst = r;
    bus0.rd = rd_v; bus0.wr = wr_v; bus0.addr = a; bus0.data_in = d;
    bus1.rd = rd_v; bus1.wr = wr_v; bus1.addr = a; bus1.data_in = d;
    acc0 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic        oe, os, ov, e_err, e_stall, e_dv, legal, acc;
      logic [3:0]  ob, e_busy;
      logic [15:0] od, e_dout;
      int          b;
      if (i == 0) begin
        oe = bus0.err; os = bus0.stall; ob = bus0.busy; ov = bus0.data_valid;
        od = bus0.data_out;
      end else begin
        oe = bus1.err; os = bus1.stall; ob = bus1.busy; ov = bus1.data_valid;
        od = bus1.data_out;
      end
      b = int'(a[2:1]);
      for (int k = 0; k < 4; k++) e_busy[k] = (free_c[i][k] > cyc);
      legal   = (rd_v != wr_v) && !a[0];
      e_err   = !r && (rd_v || wr_v) && !legal;
      e_stall = !r && legal && e_busy[b];
      acc     = !r && legal && !e_busy[b];
      e_dv    = pend_v[i][cyc];
      e_dout  = e_dv ? pend_d[i][cyc] : 16'h0000;
      check_eq($sformatf("err%0d@%0d", i, cyc), 32'(oe), 32'(e_err));
      check_eq($sformatf("stall%0d@%0d", i, cyc), 32'(os), 32'(e_stall));
      check_eq($sformatf("busy%0d@%0d", i, cyc), 32'(ob), 32'(e_busy));
      check_eq($sformatf("dvalid%0d@%0d", i, cyc), 32'(ov), 32'(e_dv));
      check_eq($sformatf("dout%0d@%0d", i, cyc), 32'(od), 32'(e_dout));
      if (r) begin
        for (int k = 0; k < 4; k++) free_c[i][k] = 0;
        if (cyc + 2 < NCYC) begin
          pend_v[i][cyc+1] = 1'b0;
          pend_v[i][cyc+2] = 1'b0;
        end
      end else if (acc) begin
        free_c[i][b] = cyc + bc[i];
        if (wr_v) mem_m[i][a[15:1]] = d;
        else if (cyc + 2 < NCYC) begin
          pend_v[i][cyc+2] = 1'b1;
          pend_d[i][cyc+2] = mem_m[i][a[15:1]];
        end
      end
      if (i == 0) acc0 = acc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, acc);
  endtask

  task automatic wait_free();
    bit acc;
    for (int k = 0; k < 20 && !all_free(); k++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, acc);
  endtask

  // Re-present a request until the BANK_CYC=4 instance takes it.
  task automatic hold(input string tag, input logic rd_v, input logic wr_v,
                      input logic [15:0] a, input logic [15:0] d);
    bit acc = 1'b0;
    for (int k = 0; k < 12 && !acc; k++) step(1'b0, rd_v, wr_v, a, d, acc);
    check_eq(tag, 32'(acc), 32'd1);
  endtask

  initial begin
    bit acc;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32768; w++) mem_m[i][w] = 16'h0000;
      for (int c = 0; c < NCYC; c++) pend_v[i][c] = 1'b0;
      for (int b = 0; b < 4; b++) free_c[i][b] = 0;
    end
    rst = 1'b1;
    bus0.rd = 1'b0; bus0.wr = 1'b0; bus0.addr = '0; bus0.data_in = '0;
    bus1.rd = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(bus0.busy), 32'd0);
    check_eq("rst_dvalid", 32'(bus0.data_valid), 32'd0);
    check_eq("rst_dout", 32'(bus0.data_out), 32'd0);
    @(posedge clk);
    #1;
    cyc = 0;

    // Single write then read-back.
    step(1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF, acc);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, acc);
    idle(3);

    // Line write-back then line fill.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 16'(16'h1230 + 2 * k), 16'(8'hA0 + k), acc);
    wait_free();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 16'(16'h1230 + 2 * k), 16'h0, acc);
    idle(3);

    // Same-bank conflict, request held until accepted.
    wait_free();
    step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, acc);
    hold("conflict_acc", 1'b1, 1'b0, 16'h0018, 16'h0);
    idle(3);

    // Illegal requests leave everything untouched.
    wait_free();
    hold("pre_err_wr", 1'b0, 1'b1, 16'h0002, 16'h1234);
    wait_free();
    step(1'b0, 1'b1, 1'b1, 16'h0004, 16'h5555, acc);
    step(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, acc);
    step(1'b0, 1'b0, 1'b1, 16'h0003, 16'hFFFF, acc);
    wait_free();
    step(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0, acc);
    idle(3);

    // Reset while a read is in flight.
    wait_free();
    step(1'b0, 1'b0, 1'b1, 16'h0040, 16'h5A5A, acc);
    wait_free();
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, acc);
    step(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0, acc);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, acc);
    idle(3);

    // Same-bank reads two cycles apart (free on the BANK_CYC=2 instance).
    wait_free();
    step(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0, acc);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 16'h000A, 16'h0, acc);
    idle(4);

    // Fill a small window, then random traffic over it.
    for (int w = 0; w < 32; w++) hold("fill_acc", 1'b0, 1'b1, 16'(2 * w), 16'($urandom));
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [15:0] a;
      r = int'($urandom_range(0, 99));
      a = 16'($urandom_range(0, 31) * 2);
      if (r < 2)       step(1'b1, r[0], 1'b0, a, 16'($urandom), acc);
      else if (r < 6)  step(1'b0, 1'b1, 1'b1, a, 16'($urandom), acc);
      else if (r < 10) step(1'b0, r[0], ~r[0], a | 16'h1, 16'($urandom), acc);
      else if (r < 25) step(1'b0, 1'b0, 1'b0, a, 16'h0, acc);
      else if (r < 60) step(1'b0, 1'b1, 1'b0, a, 16'h0, acc);
      else             step(1'b0, 1'b0, 1'b1, a, 16'($urandom), acc);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/four_bank_mem.md
Name: four_bank_mem

Overview:
- Four-way interleaved main memory. Sits directly downstream of the direct-mapped cache controller and services its line write-backs and line fills.
- The controller issues one 16-bit word request per cycle using {tag, index, offset}. Address bits [2:1] select the bank, so a 4-word line touches each bank exactly once.
- Each bank is occupied for a fixed number of cycles after an access. Read data returns with a fixed 2-cycle latency.

Parameters:
- ADDR_W, 16, byte address width; word storage = 2^(ADDR_W-1) words, split into 4 banks of 2^(ADDR_W-3) words.
- BANK_CYC, 4, cycles a bank stays occupied after accepting a request (legal range 2..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  byte address; [2:1] = bank, [ADDR_W-1:3] = row within bank, [0] must be 0.
- data_in  input  16  write data.
- wr  input  1  write request.
- rd  input  1  read request.
- data_out  output  16  read data; valid only while data_valid=1, else 0.
- data_valid  output  1  registered; high for exactly one cycle, 2 cycles after an accepted read.
- stall  output  1  combinational; request this cycle targets a busy bank and is dropped.
- busy  output  4  registered per-bank occupancy flags.
- err  output  1  combinational; illegal request this cycle (rd&wr, or addr[0]=1), dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - data_out=0, data_valid=0, busy=4'b0000.
  - All bank counters are cleared and the read pipeline is flushed.
  - Array contents are not cleared; simulation zero-initialises them at time 0.
  - Writes accepted before the reset edge remain committed.
  - While rst=1, stall=0, err=0, and no request is accepted.
- Request classification in cycle T (b = addr[2:1]):
  - none: rd=0 and wr=0. stall=0, err=0.
  - error: rd&wr, or (rd|wr)&addr[0]. err=1, stall=0, no state change.
  - stalled: legal request with busy[b]=1. stall=1, err=0, no state change.
  - accepted: legal request with busy[b]=0.
  - The requester must hold or re-present a stalled request; the block does not queue it.
- Accepted write: the bank array word at row is updated at the end of T.
- Accepted read:
  - The array word is sampled at the end of T into pipeline stage 1.
  - Stage 2 drives data_out and data_valid=1 throughout cycle T+2, then data_valid=0 unless another read was accepted in T+1.
  - Back-to-back reads to different banks produce back-to-back data_valid pulses, in issue order.
- Bank occupancy:
  - On acceptance in T, bank b's counter loads BANK_CYC-1.
  - busy[b]=1 during cycles T+1 .. T+BANK_CYC-1; the counter decrements each cycle.
  - busy[b]=0 again from cycle T+BANK_CYC, when the bank can accept a new request.
  - Counters for different banks are independent. One request per cycle, so at most one counter loads per cycle.
- Read-after-write to the same word:
  - A read can only be accepted at T+BANK_CYC or later, so it always returns the written data.
  - No bypass path is required.
- Address aliasing: addr bits above ADDR_W-1 do not exist. All ADDR_W bits are decoded; no wrap is needed.
- Read pipeline: fixed at 2 stages. data_out is never driven from the array combinationally.
- Reset during an in-flight read: the pending data_valid pulse is suppressed.
- Synthesis: no latches. The arrays are four separate single-port 16-bit memories.
- Size: a competent implementation is 150-250 lines, including the counter array and read pipeline.

Test Plan:
- Reset, then wr addr=16'h0000 data=16'hBEEF; 4 cycles later rd addr=16'h0000 -> data_valid=1 with data_out=16'hBEEF exactly 2 cycles after the read is accepted; busy=4'b0001 for cycles T+1..T+3.
- Line write-back: wr to 0x1230, 0x1232, 0x1234, 0x1236 on consecutive cycles with data 0xA0..0xA3 -> no stall; busy steps 0001, 0011, 0111, 1111, then clears bank 0 first. A line fill read of the same four addresses, starting when busy=0, returns 0xA0..0xA3 on 4 consecutive data_valid cycles.
- Bank conflict: rd 0x0010 in T, rd 0x0018 (same bank 0) in T+1 -> stall=1 in T+1..T+3 while the request is held. Accepted at T+4; its data_valid appears at T+6.
- Errors: rd=wr=1 -> err=1, stall=0, busy unchanged, no data_valid. rd with addr=16'h0003 -> err=1, no data_valid, no array change (confirmed by a later read of 0x0002).
- Reset mid-read: accept rd in T, assert rst in T+1 -> data_valid=0 at T+2 and busy=0 after the reset edge. A write accepted before reset is still readable afterwards.
- BANK_CYC=2 build: rd to bank 1 in T, rd to bank 1 in T+2 -> both accepted, no stall, two data_valid pulses at T+2 and T+4.
